// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cordic_pkg
//  Shared widths, latency, FSM state type and handy angle constants for the
//  CORDIC phase generator (2^32 = 360 degrees).
//  Revision: 1.0 - initial release
// ============================================================================
package cordic_pkg;

  localparam int PHASE_W    = 32;
  localparam int COUNT_W    = 16;
  localparam int CORDIC_LAT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] DEG45 = 32'h2000_0000;
  localparam logic [31:0] DEG90 = 32'h4000_0000;
  localparam logic [31:0] DEG1  = 32'd11930465;

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// ============================================================================
//  Module  : valid_delay_line
//  1-bit shift register mirroring the sine_cosine pipeline. tap is the input
//  delayed DEPTH cycles; any_set flags a live sample anywhere in the line;
//  empty_next says the line will hold nothing after the coming edge.
//  Revision: 1.0 - initial release
// ============================================================================
module valid_delay_line #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic tap,
  output logic any_set,
  output logic empty_next
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      // Single stage: the line is just one flop
      always_comb sr_d = in_bit;
    end else begin : g_chain
      // Shift toward the tap by one stage every cycle
      always_comb sr_d = {sr_q[DEPTH-2:0], in_bit};
    end
  endgenerate

  // Shift register, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign tap        = sr_q[DEPTH-1];
  assign any_set    = |sr_q;
  assign empty_next = ~|sr_d;

endmodule
`default_nettype wire

// File: rtl/cordic_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module  : cordic_phase_gen
//  NCO angle source for sine_cosine: issues a burst or continuous run of
//  phase angles and tracks CORDIC latency to flag valid Xout/Yout cycles.
//  Revision: 1.0 - initial release
// ============================================================================
module cordic_phase_gen #(
  parameter int PHASE_W    = cordic_pkg::PHASE_W,
  parameter int COUNT_W    = cordic_pkg::COUNT_W,
  parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT
) (
  input  logic               CLK_100MHZ,
  input  logic               RST,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] phase_init,
  input  logic [PHASE_W-1:0] phase_step,
  input  logic [COUNT_W-1:0] num_samples,
  output logic [PHASE_W-1:0] angle,
  output logic               angle_valid,
  output logic               result_valid,
  output logic               busy,
  output logic               done
);

  import cordic_pkg::state_e;
  import cordic_pkg::IDLE;
  import cordic_pkg::RUN;
  import cordic_pkg::DRAIN;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] angle_q, angle_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [COUNT_W-1:0] count_q, count_d;   // samples still to issue after the current one
  logic               cont_q, cont_d;     // continuous run: counter frozen
  logic               angle_valid_q, angle_valid_d;
  logic               done_q, done_d;

  logic               dl_tap;
  logic               dl_any_set;
  logic               dl_empty_next;
  logic               run_end;

  // Result-valid tracking through the CORDIC latency
  valid_delay_line #(
    .DEPTH (CORDIC_LAT)
  ) u_valid_delay (
    .clk        (CLK_100MHZ),
    .rst        (RST),
    .in_bit     (angle_valid_q),
    .tap        (dl_tap),
    .any_set    (dl_any_set),
    .empty_next (dl_empty_next)
  );

  // A run stops issuing after a stop request or once the burst count is spent
  assign run_end = stop || (!cont_q && (count_q == '0));

  // State and datapath registers
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      angle_q       <= '0;
      step_q        <= '0;
      count_q       <= '0;
      cont_q        <= 1'b0;
      angle_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      angle_q       <= angle_d;
      step_q        <= step_d;
      count_q       <= count_d;
      cont_q        <= cont_d;
      angle_valid_q <= angle_valid_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic; DRAIN leaves on the edge that empties the delay line
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)         state_d = RUN;
      RUN:     if (run_end)       state_d = DRAIN;
      DRAIN:   if (dl_empty_next) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath and output next values: latch on start, accumulate in RUN
  always_comb begin
    angle_d       = angle_q;
    step_d        = step_q;
    count_d       = count_q;
    cont_d        = cont_q;
    angle_valid_d = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          angle_d       = phase_init;
          step_d        = phase_step;
          cont_d        = (num_samples == '0);
          count_d       = (num_samples == '0) ? '0 : num_samples - COUNT_W'(1);
          angle_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (!run_end) begin
          angle_d       = angle_q + step_q;
          angle_valid_d = 1'b1;
          if (!cont_q) count_d = count_q - COUNT_W'(1);
        end
      end
      DRAIN: begin
        // The last live result is leaving the line on this edge
        done_d = dl_any_set && dl_empty_next;
      end
      default: ;
    endcase
  end

  assign angle        = angle_q;
  assign angle_valid  = angle_valid_q;
  assign result_valid = dl_tap;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cordic_phase_gen
//  Self-checking bench for cordic_phase_gen. Expected outputs come from a
//  closed-form timeline of each run: with start accepted at edge T and K
//  angles issued, cycle T+c has angle_valid for 1<=c<=K, angle
//  init+(c-1)*step, result_valid for LAT<c<=K+LAT, busy for c<=K+LAT and
//  done exactly at c=K+LAT+1.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cordic_phase_gen;

  localparam int PHASE_W = 32;
  localparam int COUNT_W = 16;
  localparam int LAT     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] phase_init;
  logic [PHASE_W-1:0] phase_step;
  logic [COUNT_W-1:0] num_samples;
  logic [PHASE_W-1:0] angle;
  logic               angle_valid;
  logic               result_valid;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  cordic_phase_gen #(
    .PHASE_W    (PHASE_W),
    .COUNT_W    (COUNT_W),
    .CORDIC_LAT (LAT)
  ) dut (
    .CLK_100MHZ   (clk),
    .RST          (rst),
    .start        (start),
    .stop         (stop),
    .phase_init   (phase_init),
    .phase_step   (phase_step),
    .num_samples  (num_samples),
    .angle        (angle),
    .angle_valid  (angle_valid),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One run from IDLE. stop_at>0 raises stop during cycle T+stop_at;
  // restart_at>0 pulses a start with alt_init during cycle T+restart_at.
  task automatic run(input logic [31:0] init, input logic [31:0] stp, input int n,
                     input int stop_at, input int restart_at, input logic [31:0] alt_init);
    int k;
    int dones;
    logic [31:0] expa;
    if (n == 0)                             k = stop_at;
    else if (stop_at > 0 && stop_at < n)    k = stop_at;
    else                                    k = n;
    dones = 0;
    @(negedge clk);
    phase_init  = init;
    phase_step  = stp;
    num_samples = COUNT_W'(n);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    phase_init = alt_init;
    for (int c = 1; c <= k + LAT + 3; c++) begin
      chk("angle_valid", {31'd0, angle_valid}, {31'd0, c <= k});
      chk("result_valid", {31'd0, result_valid}, {31'd0, (c > LAT) && (c - LAT <= k)});
      chk("busy", {31'd0, busy}, {31'd0, c <= k + LAT});
      chk("done", {31'd0, done}, {31'd0, c == k + LAT + 1});
      if (done) dones++;
      if (c <= k) begin
        expa = init + stp * 32'(c - 1);
        chk("angle", angle, expa);
      end
      stop  = (c == stop_at);
      start = (c == restart_at);
      @(posedge clk);
      #1;
    end
    stop  = 1'b0;
    start = 1'b0;
    expa  = init + stp * 32'(k - 1);
    chk("angle_hold", angle, expa);
    chk("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    logic [31:0] ri, rs;
    int rn, rstop;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    phase_init = '0; phase_step = '0; num_samples = '0;
    #1;
    // Reset state
    chk("rst_angle", angle, 32'd0);
    chk("rst_flags", {28'd0, angle_valid, result_valid, busy, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // stop while IDLE is ignored
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);

    // Burst of four 45-degree steps
    run(32'h0000_0000, 32'h2000_0000, 4, 0, 0, 32'h0);
    // Silent wrap past 360 degrees
    run(32'hF000_0000, 32'h2000_0000, 3, 0, 0, 32'h0);
    // Continuous, stopped after five angles
    run(32'h0000_0000, 32'd11930465, 0, 5, 0, 32'h0);
    // start during RUN must not re-latch
    run(32'h1234_5678, 32'h0100_0000, 6, 0, 2, 32'hDEAD_BEEF);
    // start during DRAIN must not re-latch either
    run(32'h0000_0100, 32'h0000_0010, 2, 0, 8, 32'hCAFE_0000);
    // Single 45-degree sample for the sine_cosine case
    run(32'h2000_0000, 32'h0000_0000, 1, 0, 0, 32'h0);
    // stop on the last burst cycle and stop during DRAIN
    run(32'h0000_0001, 32'h0000_0003, 3, 3, 0, 32'h0);
    run(32'h0000_0001, 32'h0000_0003, 3, 9, 0, 32'h0);

    // Reset mid-run
    @(negedge clk);
    phase_init = 32'h0A00_0000; phase_step = 32'h0000_1000; num_samples = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (LAT + 2) begin @(posedge clk); #1; end
    chk("pre_rst_rv", {31'd0, result_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_angle", angle, 32'd0);
    chk("mid_rst_flags", {28'd0, angle_valid, result_valid, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {29'd0, result_valid, busy, done}, 32'd0);
    end
    run(32'h0B00_0000, 32'h0000_2000, 2, 0, 0, 32'h0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      ri = $urandom;
      rs = $urandom;
      rn = int'($urandom_range(0, 12));
      if (rn == 0) rstop = int'($urandom_range(1, 10));
      else         rstop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rn + LAT)) : 0;
      run(ri, rs, rn, rstop, 0, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
